// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch PC sequencer: issues one req/ack fetch at the current PC, then
// loads PCNext (redirect, pending redirect or PC+INC) and pulses PCWrite for one cycle.
module pc_fetch_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INC = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic [ADDR_W-1:0] pc_current,
  output logic [ADDR_W-1:0] PCNext,
  output logic              PCWrite,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic [2:0]        dbg_state
);

  localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_UPD    = 3'd3;
  localparam logic [2:0] S_STALL  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic              ack_xfer;
  logic              redirect_live;
  logic [ADDR_W-1:0] pc_seq;
  logic [WCNT_W-1:0] wait_cnt;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              halt_flag;

  assign dbg_state = state;
  assign pc_seq = pc_current + ADDR_W'(INC);
  assign redirect_live = redirect_valid &&
                         (state == S_REQ || state == S_WAIT || state == S_UPD || state == S_STALL);

  // Handshake: imem_req rises with a registered imem_addr and both hold unchanged
  // until imem_ack is seen high on a rising edge; that edge completes the fetch.
  always_comb begin
    state_nx = state;
    ack_xfer = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          state_nx = S_UPD;
          ack_xfer = 1'b1;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_nx = S_UPD;
          ack_xfer = 1'b1;
        end else if (wait_cnt == WCNT_W'(MAX_WAIT - 1)) begin
          state_nx = S_ERR;
        end
      end
      S_UPD: begin
        if (halt_flag)  state_nx = S_HALTED;
        else if (stall) state_nx = S_STALL;
        else            state_nx = S_REQ;
      end
      S_STALL:  if (!stall) state_nx = S_REQ;
      S_HALTED: if (start) state_nx = S_REQ;
      S_ERR:    state_nx = S_ERR;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      PCNext      <= RESET_VEC;
      PCWrite     <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      halt_flag   <= 1'b0;
    end else begin
      state       <= state_nx;
      PCWrite     <= (state_nx == S_UPD);
      instr_valid <= (state_nx == S_UPD);
      imem_req    <= (state_nx == S_REQ) || (state_nx == S_WAIT);
      busy        <= (state_nx == S_REQ) || (state_nx == S_WAIT) ||
                     (state_nx == S_UPD) || (state_nx == S_STALL);
      timeout_err <= (state_nx == S_ERR);

      // Leaving UPD, the PC register is loading PCNext on this same edge, so that
      // value is the address the next fetch must use.
      if (state_nx == S_REQ && state != S_REQ) begin
        imem_addr <= (state == S_UPD) ? PCNext : pc_current;
      end

      if (state_nx == S_REQ) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end

      if (ack_xfer) begin
        if (redirect_valid)  PCNext <= redirect_addr;
        else if (pend_valid) PCNext <= pend_addr;
        else                 PCNext <= pc_seq;
        halt_flag  <= halt;
        pend_valid <= 1'b0;
      end else if (redirect_live) begin
        pend_valid <= 1'b1;
        pend_addr  <= redirect_addr;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a behavioural PC register closes the loop,
// and every PCWrite is scored against a queue of hand-computed PCNext values.
module tb_pc_fetch_sequencer;

  localparam int ST_IDLE   = 0;
  localparam int ST_STALL  = 4;
  localparam int ST_HALTED = 5;
  localparam int ST_ERR    = 6;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic [31:0] pc_current;
  logic [31:0] PCNext;
  logic        PCWrite;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic        busy;
  logic        timeout_err;
  logic [2:0]  dbg_state;

  logic        pc_load = 1'b1;
  logic [31:0] pc_load_val = '0;
  logic [31:0] pc_q;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  pc_fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stall(stall), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .pc_current(pc_current), .PCNext(PCNext), .PCWrite(PCWrite),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .busy(busy), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // behavioural PC register
  always @(posedge Clk) begin
    if (pc_load)      pc_q <= pc_load_val;
    else if (PCWrite) pc_q <= PCNext;
  end
  assign pc_current = pc_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard
  always @(negedge Clk) begin
    if (PCWrite || instr_valid) begin
      check("instr_valid_eq_pcwrite", 32'(instr_valid), 32'(PCWrite));
      if (exp_q.size() == 0) check("pcwrite_unexpected", 32'(PCWrite), 32'd0);
      else                   check("pcnext", PCNext, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input int dly, input logic [31:0] exp_addr, input logic [31:0] exp_next,
                       input logic redir, input logic [31:0] raddr, input logic hlt);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    if (!imem_req) return;
    check("imem_addr", imem_addr, exp_addr);
    exp_q.push_back(exp_next);
    for (int i = 0; i < dly; i++) begin
      tick();
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, exp_addr);
      check("no_early_pcwrite", 32'(PCWrite), 32'd0);
    end
    imem_ack = 1'b1;
    redirect_valid = redir;
    redirect_addr = raddr;
    halt = hlt;
    tick();
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    check("upd_req_low", 32'(imem_req), 32'd0);
  endtask

  initial begin
    int n;
    tick();
    tick();
    Reset = 1'b0;
    pc_load = 1'b0;
    check("rst_state", 32'(dbg_state), ST_IDLE);
    check("rst_pcnext", PCNext, 32'h0);
    check("rst_pcwrite", 32'(PCWrite), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);

    // sequential fetch, ack in the first request cycle
    start = 1'b1;
    fetch(0, 32'h0, 32'h4, 1'b0, 32'h0, 1'b0);
    start = 1'b0;
    check("seq_busy", 32'(busy), 32'd1);
    fetch(0, 32'h4, 32'h8, 1'b0, 32'h0, 1'b0);
    fetch(0, 32'h8, 32'hC, 1'b0, 32'h0, 1'b0);

    // five wait states
    fetch(5, 32'hC, 32'h10, 1'b0, 32'h0, 1'b0);
    check("wait_no_timeout", 32'(timeout_err), 32'd0);

    // redirect in the ack cycle
    fetch(0, 32'h10, 32'h200, 1'b1, 32'h200, 1'b0);

    // redirect while stalled becomes pending
    stall = 1'b1;
    tick();
    check("stall_state", 32'(dbg_state), ST_STALL);
    check("stall_busy", 32'(busy), 32'd1);
    redirect_valid = 1'b1;
    redirect_addr = 32'h300;
    tick();
    redirect_valid = 1'b0;
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_pcwrite_low", 32'(PCWrite), 32'd0);
    stall = 1'b0;
    fetch(0, 32'h200, 32'h300, 1'b0, 32'h0, 1'b0);
    fetch(0, 32'h300, 32'h304, 1'b0, 32'h0, 1'b0);

    // redirect in UPD: one sequential fetch completes first
    redirect_valid = 1'b1;
    redirect_addr = 32'h500;
    tick();
    redirect_valid = 1'b0;
    fetch(0, 32'h304, 32'h500, 1'b0, 32'h0, 1'b0);

    // halt with PC wrap
    stall = 1'b1;
    tick();
    pc_load = 1'b1;
    pc_load_val = 32'hFFFF_FFFC;
    tick();
    pc_load = 1'b0;
    stall = 1'b0;
    fetch(0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    check("halted_state", 32'(dbg_state), ST_HALTED);
    check("halted_busy", 32'(busy), 32'd0);
    redirect_valid = 1'b1;
    redirect_addr = 32'h700;
    tick();
    redirect_valid = 1'b0;
    check("halted_hold", 32'(dbg_state), ST_HALTED);
    check("halted_req_low", 32'(imem_req), 32'd0);
    start = 1'b1;
    fetch(0, 32'h0, 32'h4, 1'b0, 32'h0, 1'b0);
    start = 1'b0;

    // reset during WAIT with a pending redirect
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_addr = 32'h900;
    tick();
    redirect_valid = 1'b0;
    check("pre_reset_req", 32'(imem_req), 32'd1);
    Reset = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 32'h0;
    tick();
    check("midrst_state", 32'(dbg_state), ST_IDLE);
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_pcnext", PCNext, 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    Reset = 1'b0;
    pc_load = 1'b0;
    start = 1'b1;
    fetch(0, 32'h0, 32'h4, 1'b0, 32'h0, 1'b0);
    start = 1'b0;

    // timeout: ack never arrives
    n = 0;
    while (!imem_req && n < 5) begin
      tick();
      n++;
    end
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      tick();
    end
    check("req_cycles_before_err", 32'(n), 32'd16);
    check("err_state", 32'(dbg_state), ST_ERR);
    check("err_flag", 32'(timeout_err), 32'd1);
    check("err_req_low", 32'(imem_req), 32'd0);
    check("err_busy", 32'(busy), 32'd0);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    check("err_sticky", 32'(timeout_err), 32'd1);
    check("err_stays", 32'(dbg_state), ST_ERR);
    check("err_req_stays_low", 32'(imem_req), 32'd0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("post_err_state", 32'(dbg_state), ST_IDLE);
    check("post_err_timeout", 32'(timeout_err), 32'd0);
    check("post_err_req", 32'(imem_req), 32'd0);
    check("post_err_pcwrite", 32'(PCWrite), 32'd0);
    check("post_err_ivalid", 32'(instr_valid), 32'd0);
    check("post_err_busy", 32'(busy), 32'd0);
    check("post_err_pcnext", PCNext, 32'h0);

    tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
